man_charge_meter: RTL and testbench

- Parametrised jump-charge meter for the player character.
- While the game FSM sits in the accumulate state, an internal tick-enabled counter builds a charge level. Mode is either saturating or ping-pong (oscillating).
- On release, the block latches the charge for the jump-distance logic, emits a one-cycle valid pulse, then decays the squeeze level back to zero for the sprite renderer.
- Single clock domain: the prescaler produces an enable, never a derived clock.

---
 rtl/man_charge_meter.sv | 167 ++++++++++++++++
 tb/tb_man_charge_meter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/man_charge_meter.sv
// Jump-charge meter: builds a charge level while the game FSM accumulates,
// latches it on release, then decays the squeeze level back to zero.
module man_charge_meter #(
   parameter int         PRESCALE_DIV = 524288,
   parameter int         CNT_W        = 4,
   parameter int         LVL_W        = 3,
   parameter logic [2:0] ACCU_CODE    = 3'd1,
   parameter bit         PINGPONG     = 1'b0,
   parameter int         DECAY_STEP   = 2
) (
   input  logic             clk_machine,
   input  logic             rst_machine,
   input  logic [2:0]       state,
   output logic [LVL_W-1:0] o_level,
   output logic [CNT_W-1:0] o_charge,
   output logic             o_charge_valid,
   output logic             o_full,
   output logic             o_busy
);

   localparam int               PRE_W    = $clog2(PRESCALE_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic             DIR_UP   = 1'b0;
   localparam logic             DIR_DOWN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CHARGE  = 2'd1,
      ST_RELEASE = 2'd2
   } st_t;

   st_t              r_st;
   st_t              w_st_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_dec;
   logic [PRE_W-1:0] r_pre;
   logic [PRE_W-1:0] w_pre_nxt;
   logic             r_dir;
   logic             w_dir_nxt;
   logic [CNT_W-1:0] r_charge;
   logic             r_valid;
   logic             w_latch;
   logic             w_tick;
   logic             w_accu;

   // Saturating subtract so the decay never wraps below zero.
   function automatic logic [CNT_W-1:0] f_decay(input logic [CNT_W-1:0] cnt);
      logic [CNT_W:0] step;
      step = (CNT_W+1)'(DECAY_STEP);
      if ({1'b0, cnt} > step) begin
         f_decay = cnt - step[CNT_W-1:0];
      end else begin
         f_decay = CNT_ZERO;
      end
   endfunction

   assign w_tick    = (r_pre == PRE_LAST);
   assign w_accu    = (state == ACCU_CODE);
   assign w_cnt_dec = f_decay(r_cnt);

   // Next-state and datapath decode.
   always_comb begin
      w_st_nxt  = r_st;
      w_cnt_nxt = r_cnt;
      w_dir_nxt = r_dir;
      w_pre_nxt = w_tick ? {PRE_W{1'b0}} : (r_pre + PRE_W'(1));
      w_latch   = 1'b0;
      case (r_st)
         ST_IDLE: begin
            w_cnt_nxt = CNT_ZERO;
            w_dir_nxt = DIR_UP;
            w_pre_nxt = {PRE_W{1'b0}};
            if (w_accu) begin
               w_st_nxt = ST_CHARGE;
            end else begin
               w_st_nxt = ST_IDLE;
            end
         end
         ST_CHARGE: begin
            if (!w_accu) begin
               // Latch the pre-tick value; a coincident tick is dropped.
               w_latch  = 1'b1;
               w_st_nxt = ST_RELEASE;
            end else if (w_tick) begin
               if (PINGPONG) begin
                  if (r_cnt == CNT_MAX) begin
                     w_cnt_nxt = r_cnt - CNT_W'(1);
                     w_dir_nxt = DIR_DOWN;
                  end else if (r_cnt == CNT_ZERO) begin
                     w_cnt_nxt = r_cnt + CNT_W'(1);
                     w_dir_nxt = DIR_UP;
                  end else if (r_dir == DIR_DOWN) begin
                     w_cnt_nxt = r_cnt - CNT_W'(1);
                  end else begin
                     w_cnt_nxt = r_cnt + CNT_W'(1);
                  end
               end else if (r_cnt != CNT_MAX) begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end else begin
                  w_cnt_nxt = r_cnt;
               end
            end else begin
               w_st_nxt = ST_CHARGE;
            end
         end
         ST_RELEASE: begin
            if (w_accu) begin
               w_st_nxt  = ST_CHARGE;
               w_pre_nxt = {PRE_W{1'b0}};
               w_dir_nxt = DIR_UP;
            end else if (r_cnt == CNT_ZERO) begin
               w_st_nxt  = ST_IDLE;
               w_pre_nxt = {PRE_W{1'b0}};
            end else if (w_tick) begin
               w_cnt_nxt = w_cnt_dec;
               if (w_cnt_dec == CNT_ZERO) begin
                  w_st_nxt  = ST_IDLE;
                  w_pre_nxt = {PRE_W{1'b0}};
               end else begin
                  w_st_nxt = ST_RELEASE;
               end
            end else begin
               w_st_nxt = ST_RELEASE;
            end
         end
         default: begin
            w_st_nxt  = ST_IDLE;
            w_cnt_nxt = CNT_ZERO;
            w_dir_nxt = DIR_UP;
            w_pre_nxt = {PRE_W{1'b0}};
         end
      endcase
   end

   // State, counter, prescaler and release-latch registers.
   always_ff @(posedge clk_machine) begin
      if (!rst_machine) begin
         r_st     <= ST_IDLE;
         r_cnt    <= CNT_ZERO;
         r_pre    <= {PRE_W{1'b0}};
         r_dir    <= DIR_UP;
         r_charge <= CNT_ZERO;
         r_valid  <= 1'b0;
      end else begin
         r_st    <= w_st_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pre   <= w_pre_nxt;
         r_dir   <= w_dir_nxt;
         r_valid <= w_latch;
         if (w_latch) begin
            r_charge <= r_cnt;
         end else begin
            r_charge <= r_charge;
         end
      end
   end

   assign o_level        = r_cnt[CNT_W-1 -: LVL_W];
   assign o_charge       = r_charge;
   assign o_charge_valid = r_valid;
   assign o_full         = (r_cnt == CNT_MAX);
   assign o_busy         = (r_st != ST_IDLE);

endmodule

// File: tb/tb_man_charge_meter.sv
// Bench for man_charge_meter: saturating and ping-pong instances share one
// stimulus and are compared every cycle against a segment-based charge model.
module tb_man_charge_meter;

   localparam int DIV  = 4;
   localparam int MAXC = 15;
   localparam int DEC  = 2;

   logic       clk;
   logic       rst;
   logic [2:0] state;

   logic [2:0] lvl0, lvl1;
   logic [3:0] chg0, chg1;
   logic       vld0, vld1, full0, full1, busy0, busy1;

   int n_checks = 0;
   int n_err    = 0;
   bit cmp_en   = 1'b0;

   // Model: per instance a mode (0 idle, 1 charge, 2 release), the count at
   // the start of the segment, ticks seen in it, and cycles since the tick
   // counter was last cleared.
   int m_mode   [2] = '{0, 0};
   int m_base   [2] = '{0, 0};
   int m_ticks  [2] = '{0, 0};
   int m_cyc    [2] = '{0, 0};
   int m_charge [2] = '{0, 0};
   int m_valid  [2] = '{0, 0};

   man_charge_meter #(.PRESCALE_DIV(DIV), .CNT_W(4), .LVL_W(3), .ACCU_CODE(3'd1),
                      .PINGPONG(1'b0), .DECAY_STEP(DEC)) dut_sat (
      .clk_machine(clk), .rst_machine(rst), .state(state),
      .o_level(lvl0), .o_charge(chg0), .o_charge_valid(vld0),
      .o_full(full0), .o_busy(busy0));

   man_charge_meter #(.PRESCALE_DIV(DIV), .CNT_W(4), .LVL_W(3), .ACCU_CODE(3'd1),
                      .PINGPONG(1'b1), .DECAY_STEP(DEC)) dut_pp (
      .clk_machine(clk), .rst_machine(rst), .state(state),
      .o_level(lvl1), .o_charge(chg1), .o_charge_valid(vld1),
      .o_full(full1), .o_busy(busy1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int mcnt(input int k);
      int p;
      if (m_mode[k] == 1) begin
         if (k == 1) begin
            p = (m_base[k] + m_ticks[k]) % (2 * MAXC);
            return (p <= MAXC) ? p : (2 * MAXC - p);
         end
         return (m_base[k] + m_ticks[k] > MAXC) ? MAXC : (m_base[k] + m_ticks[k]);
      end else if (m_mode[k] == 2) begin
         p = m_base[k] - DEC * m_ticks[k];
         return (p < 0) ? 0 : p;
      end
      return 0;
   endfunction

   task automatic model_step(input int k);
      int c;
      bit tk;
      bit accu;
      c    = mcnt(k);
      tk   = ((m_cyc[k] % DIV) == DIV - 1);
      accu = (state == 3'd1);
      if (!rst) begin
         m_mode[k] = 0; m_base[k] = 0; m_ticks[k] = 0; m_cyc[k] = 0;
         m_charge[k] = 0; m_valid[k] = 0;
      end else begin
         m_valid[k] = 0;
         if (m_mode[k] == 0) begin
            m_cyc[k] = 0;
            if (accu) begin m_mode[k] = 1; m_base[k] = 0; m_ticks[k] = 0; end
         end else if (m_mode[k] == 1) begin
            if (!accu) begin
               m_charge[k] = c; m_valid[k] = 1;
               m_mode[k] = 2; m_base[k] = c; m_ticks[k] = 0;
            end else if (tk) begin
               m_ticks[k]++;
            end
            m_cyc[k]++;
         end else begin
            if (accu) begin
               m_mode[k] = 1; m_base[k] = c; m_ticks[k] = 0; m_cyc[k] = 0;
            end else if (c == 0) begin
               m_mode[k] = 0; m_cyc[k] = 0;
            end else begin
               if (tk) m_ticks[k]++;
               m_cyc[k]++;
               if (mcnt(k) == 0) begin m_mode[k] = 0; m_cyc[k] = 0; end
            end
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_inst(input int k, input int lvl, input int chg, input int vld,
                           input int full, input int busy);
      int c;
      c = mcnt(k);
      chk($sformatf("u%0d_level", k),  lvl,  c / 2);
      chk($sformatf("u%0d_charge", k), chg,  m_charge[k]);
      chk($sformatf("u%0d_valid", k),  vld,  m_valid[k]);
      chk($sformatf("u%0d_full", k),   full, (c == MAXC) ? 1 : 0);
      chk($sformatf("u%0d_busy", k),   busy, (m_mode[k] != 0) ? 1 : 0);
   endtask

   initial forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         cmp_inst(0, int'(lvl0), int'(chg0), int'(vld0), int'(full0), int'(busy0));
         cmp_inst(1, int'(lvl1), int'(chg1), int'(vld1), int'(full1), int'(busy1));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; state = 3'd1;
      cyc(1); cmp_en = 1'b1;
      cyc(2);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_charge", int'(chg0), 0);
      chk("rst_level", int'(lvl0), 0);

      rst = 1'b1;
      cyc(1);  chk("enter_charge_busy", int'(busy0), 1);
      cyc(59); chk("sat_c59_level", int'(lvl0), 7); chk("sat_c59_full", int'(full0), 0);
      cyc(1);  chk("sat_c60_full", int'(full0), 1); chk("sat_c60_level", int'(lvl0), 7);
               chk("model_sat_c60", mcnt(0), 15); chk("pp_t15_full", int'(full1), 1);
      cyc(4);  chk("pp_t16_level", int'(lvl1), 7); chk("pp_t16_full", int'(full1), 0);
      cyc(16); chk("sat_c80_full", int'(full0), 1); chk("pp_t20_level", int'(lvl1), 5);
      cyc(40); chk("pp_t30_level", int'(lvl1), 0); chk("model_pp_t30", mcnt(1), 0);
      cyc(4);  chk("model_pp_t31", mcnt(1), 1);

      state = 3'd0;
      cyc(1);  chk("rel_sat_valid", int'(vld0), 1); chk("rel_sat_charge", int'(chg0), 15);
               chk("rel_pp_charge", int'(chg1), 1);
      cyc(1);  chk("rel_valid_once", int'(vld0), 0);
      cyc(2);  chk("decay_13_level", int'(lvl0), 6); chk("pp_idle_busy", int'(busy1), 0);
      cyc(27); chk("decay_1_busy", int'(busy0), 1); chk("decay_1_level", int'(lvl0), 0);
      cyc(1);  chk("decay_idle_busy", int'(busy0), 0);

      state = 3'd1;
      cyc(1);  chk("recharge_busy", int'(busy0), 1);
      cyc(44); chk("c11_level", int'(lvl0), 5);
      state = 3'd6;
      cyc(1);  chk("rel11_valid", int'(vld0), 1); chk("rel11_charge", int'(chg0), 11);
      cyc(3);  chk("decay9_level", int'(lvl0), 4);
      state = 3'd1;
      cyc(1);  chk("repress_no_valid", int'(vld0), 0); chk("repress_busy", int'(busy0), 1);
      cyc(4);  chk("repress_c10_level", int'(lvl0), 5);

      rst = 1'b0;
      cyc(1);  chk("midrst_valid", int'(vld0), 0); chk("midrst_charge", int'(chg0), 0);
               chk("midrst_busy", int'(busy0), 0);
      rst = 1'b1;
      cyc(1);
      cyc(27); chk("c6_level", int'(lvl0), 3);
      state = 3'd5;
      cyc(1);  chk("tick_release_charge", int'(chg0), 6); chk("tick_release_valid", int'(vld0), 1);
      cyc(14); chk("c6_decay_idle", int'(busy0), 0);

      state = 3'd1;
      cyc(10); chk("pre_rst_busy", int'(busy0), 1);
      state = 3'd0; rst = 1'b0;
      cyc(1);  chk("rst_rel_valid", int'(vld0), 0); chk("rst_rel_charge", int'(chg0), 0);
      cyc(1);  chk("rst_rel_valid2", int'(vld0), 0);
      rst = 1'b1;
      cyc(3);  chk("final_busy", int'(busy0), 0);

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
